// File: rtl/spi_regfile_bridge_if.sv
// SPI pins of the register-file bridge: the master drives chip select and MOSI,
// and the slave drives MISO back.
interface spi_regfile_bridge_if;
   logic SS;
   logic MOSI;
   logic MISO;

   modport master (output SS, output MOSI, input MISO);
   modport slave  (input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_regfile_bridge.sv
// SPI slave that decodes opcode/address/data frames into byte and burst accesses
// on a DEPTH-byte register file, plus ready flags and a sticky address-error bit.
module spi_regfile_bridge #(
   parameter int unsigned DEPTH   = 66,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned N_FLAGS = 3
) (
   input  logic                 SCLK,
   input  logic                 RESET_N,
   spi_regfile_bridge_if.slave  spi,
   output logic [DEPTH*8-1:0]   all_data_out,
   output logic [N_FLAGS-1:0]   ready_flags,
   output logic                 addr_error,
   output logic                 byte_valid,
   output logic                 instr_done
);
   localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
   localparam int unsigned ACC_W      = ADDR_BYTES * 8;
   localparam int unsigned ABC_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

   typedef enum logic [2:0] {
      StOpcode, StAddr, StWdata, StRdata, StStatus, StFlagOp, StIgnore
   } state_e;

   state_e             state_q;
   logic [2:0]         bit_cnt_q;
   logic [6:0]         rx_q;
   logic [7:0]         tx_q;
   logic [ADDR_W-1:0]  ptr_q;
   logic [ACC_W-1:0]   addr_acc_q;
   logic [ABC_W-1:0]   addr_cnt_q;
   logic               rd_op_q;
   logic               addr_ok_q;
   logic               status_first_q;
   logic [DEPTH*8-1:0] mem_q;

   logic               frame_rst_n;
   logic               byte_done;
   logic [7:0]         rx_byte;
   logic [ACC_W-1:0]   addr_next;
   logic [ADDR_W-1:0]  new_addr;
   logic               new_ok;
   logic               last_addr;
   logic [ADDR_W-1:0]  ptr_inc;
   logic [ADDR_W-1:0]  rd_addr;
   logic               rd_ok;
   logic [7:0]         rd_data;
   logic               is_set;
   logic               is_clr;

   // Chip select doubles as an asynchronous clear for everything frame-scoped.
   assign frame_rst_n = RESET_N & ~spi.SS;

   assign byte_done = (bit_cnt_q == 3'd7);
   assign rx_byte   = {rx_q, spi.MOSI};
   assign addr_next = (addr_acc_q << 8) | ACC_W'(rx_byte);
   assign new_addr  = addr_next[ADDR_W-1:0];
   assign new_ok    = (32'(new_addr) < DEPTH);
   assign last_addr = (addr_cnt_q == ABC_W'(ADDR_BYTES - 1));
   assign ptr_inc   = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
   assign is_set    = (rx_byte[7:3] == 5'b10000);
   assign is_clr    = (rx_byte[7:3] == 5'b01000);

   // Read data is fetched for the pointer value that will be live after this edge.
   assign rd_addr = (state_q == StAddr) ? new_addr : ptr_inc;
   assign rd_ok   = (state_q == StAddr) ? new_ok : addr_ok_q;

   always_comb begin
      rd_data = '0;
      for (int a = 0; a < int'(DEPTH); a++) begin
         if (rd_ok && rd_addr == ADDR_W'(a)) rd_data = mem_q[8*a +: 8];
      end
   end

   assign spi.MISO     = tx_q[7] & ((state_q == StRdata) || (state_q == StStatus));
   assign all_data_out = mem_q;

   always_ff @(posedge SCLK or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         state_q        <= StOpcode;
         bit_cnt_q      <= '0;
         rx_q           <= '0;
         tx_q           <= '0;
         ptr_q          <= '0;
         addr_acc_q     <= '0;
         addr_cnt_q     <= '0;
         rd_op_q        <= 1'b0;
         addr_ok_q      <= 1'b0;
         status_first_q <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_q + 3'd1;
         rx_q      <= rx_byte[6:0];
         tx_q      <= {tx_q[6:0], 1'b0};
         if (byte_done) begin
            unique case (state_q)
               StOpcode: begin
                  if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                     state_q    <= StAddr;
                     rd_op_q    <= rx_byte[1];
                     addr_cnt_q <= '0;
                     addr_acc_q <= '0;
                  end else if (rx_byte == 8'h03) begin
                     state_q        <= StStatus;
                     tx_q           <= {addr_error, 7'(ready_flags)};
                     status_first_q <= 1'b1;
                  end else if (is_set || is_clr) begin
                     state_q <= StFlagOp;
                  end else begin
                     state_q <= StIgnore;
                  end
               end
               StAddr: begin
                  addr_acc_q <= addr_next;
                  if (last_addr) begin
                     ptr_q     <= new_addr;
                     addr_ok_q <= new_ok;
                     if (rd_op_q) begin
                        state_q <= StRdata;
                        tx_q    <= rd_data;
                     end else begin
                        state_q <= StWdata;
                     end
                  end else begin
                     addr_cnt_q <= addr_cnt_q + ABC_W'(1);
                  end
               end
               StWdata: begin
                  if (addr_ok_q) ptr_q <= ptr_inc;
               end
               StRdata: begin
                  if (addr_ok_q) ptr_q <= ptr_inc;
                  tx_q <= rd_data;
               end
               StStatus: begin
                  // The error bit is cleared by the first status byte and cannot re-arm here.
                  status_first_q <= 1'b0;
                  tx_q           <= {1'b0, 7'(ready_flags)};
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge SCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mem_q       <= '0;
         ready_flags <= '0;
         addr_error  <= 1'b0;
         byte_valid  <= 1'b0;
         instr_done  <= 1'b0;
      end else begin
         byte_valid <= byte_done;
         instr_done <= 1'b0;
         if (byte_done) begin
            unique case (state_q)
               StOpcode: begin
                  if (is_set || is_clr) begin
                     instr_done <= 1'b1;
                     for (int f = 0; f < int'(N_FLAGS); f++) begin
                        if (rx_byte[2:0] == 3'(f)) ready_flags[f] <= is_set;
                     end
                  end
               end
               StAddr: begin
                  if (last_addr && !new_ok) addr_error <= 1'b1;
               end
               StWdata: begin
                  instr_done <= 1'b1;
                  for (int a = 0; a < int'(DEPTH); a++) begin
                     if (addr_ok_q && ptr_q == ADDR_W'(a)) mem_q[8*a +: 8] <= rx_byte;
                  end
               end
               StRdata: instr_done <= 1'b1;
               StStatus: begin
                  if (status_first_q) addr_error <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_regfile_bridge.sv
// Scoreboard bench: each sent byte queues the state expected once it completes,
// and a falling-edge monitor checks it against the bridge on every byte_valid.
module tb_spi_regfile_bridge;
   localparam int DEPTH = 66;

   typedef struct {
      logic               chk_miso;
      logic [7:0]         miso;
      logic               instr;
      logic [DEPTH*8-1:0] mem;
      logic [2:0]         flags;
      logic               err;
   } exp_t;

   logic SCLK = 1'b0;
   logic RESET_N;
   always #5 SCLK = ~SCLK;

   spi_regfile_bridge_if if_a ();
   spi_regfile_bridge_if if_b ();

   logic [DEPTH*8-1:0] data_a, data_b;
   logic [2:0]         flags_a, flags_b;
   logic               err_a, err_b, bv_a, bv_b, id_a, id_b;

   spi_regfile_bridge #(.DEPTH(DEPTH), .ADDR_W(8), .N_FLAGS(3)) dut_a (
      .SCLK(SCLK), .RESET_N(RESET_N), .spi(if_a), .all_data_out(data_a),
      .ready_flags(flags_a), .addr_error(err_a), .byte_valid(bv_a), .instr_done(id_a)
   );

   spi_regfile_bridge #(.DEPTH(DEPTH), .ADDR_W(16), .N_FLAGS(3)) dut_b (
      .SCLK(SCLK), .RESET_N(RESET_N), .spi(if_b), .all_data_out(data_b),
      .ready_flags(flags_b), .addr_error(err_b), .byte_valid(bv_b), .instr_done(id_b)
   );

   int total = 0;
   int bad   = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   logic [7:0] sh_a = '0, sh_b = '0;

   logic [DEPTH*8-1:0] exp_mem_a, exp_mem_b;
   logic [2:0]         exp_flags;
   logic               exp_err;

   task automatic cmp(input string name, input logic [DEPTH*8-1:0] act,
                      input logic [DEPTH*8-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_entry(input string tag, input exp_t e, input logic id,
                              input logic [7:0] sh, input logic [DEPTH*8-1:0] mem,
                              input logic [2:0] flags, input logic err);
      cmp({tag, "_instr_done"}, {{(DEPTH*8-1){1'b0}}, id}, {{(DEPTH*8-1){1'b0}}, e.instr});
      cmp({tag, "_mem"}, mem, e.mem);
      cmp({tag, "_flags"}, {{(DEPTH*8-3){1'b0}}, flags}, {{(DEPTH*8-3){1'b0}}, e.flags});
      cmp({tag, "_addr_error"}, {{(DEPTH*8-1){1'b0}}, err}, {{(DEPTH*8-1){1'b0}}, e.err});
      if (e.chk_miso) cmp({tag, "_miso_byte"}, {{(DEPTH*8-8){1'b0}}, sh},
                          {{(DEPTH*8-8){1'b0}}, e.miso});
   endtask

   // Master samples MISO on the falling edge; a byte's bits are the eight samples
   // taken before the falling edge at which its byte_valid is seen.
   always @(negedge SCLK) begin
      if (bv_a) begin
         if (q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte_valid_a: got 1 expected 0");
         end else begin
            ea = q_a.pop_front();
            check_entry("a", ea, id_a, sh_a, data_a, flags_a, err_a);
         end
      end else if (id_a) begin
         cmp("a_instr_without_byte", 1, 0);
      end
      if (bv_b) begin
         if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte_valid_b: got 1 expected 0");
         end else begin
            eb = q_b.pop_front();
            check_entry("b", eb, id_b, sh_b, data_b, flags_b, err_b);
         end
      end
      if (!if_a.SS) sh_a = {sh_a[6:0], if_a.MISO};
      if (!if_b.SS) sh_b = {sh_b[6:0], if_b.MISO};
   end

   task automatic start(input int d);
      @(negedge SCLK);
      if (d == 0) if_a.SS = 1'b0;
      else        if_b.SS = 1'b0;
   endtask

   task automatic bits(input logic [7:0] b, input int n);
      for (int i = 7; i >= 8 - n; i--) begin
         if_a.MOSI = b[i];
         if_b.MOSI = b[i];
         @(negedge SCLK);
      end
   endtask

   task automatic xfer(input int d, input logic [7:0] b, input logic chk,
                       input logic [7:0] m, input logic instr);
      exp_t e;
      e.chk_miso = chk;
      e.miso     = m;
      e.instr    = instr;
      if (d == 0) begin
         e.mem = exp_mem_a; e.flags = exp_flags; e.err = exp_err;
         q_a.push_back(e);
      end else begin
         e.mem = exp_mem_b; e.flags = 3'b000; e.err = 1'b0;
         q_b.push_back(e);
      end
      bits(b, 8);
   endtask

   task automatic stop();
      if_a.SS   = 1'b1;
      if_b.SS   = 1'b1;
      if_a.MOSI = 1'b0;
      if_b.MOSI = 1'b0;
      repeat (2) @(negedge SCLK);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      RESET_N = 1'b0;
      if_a.SS = 1'b1; if_b.SS = 1'b1; if_a.MOSI = 1'b0; if_b.MOSI = 1'b0;
      exp_mem_a = '0; exp_mem_b = '0; exp_flags = 3'b000; exp_err = 1'b0;
      repeat (3) @(negedge SCLK);
      cmp("rst_data_a", data_a, '0);
      cmp("rst_flags_a", {{(DEPTH*8-3){1'b0}}, flags_a}, '0);
      cmp("rst_err_a", {{(DEPTH*8-1){1'b0}}, err_a}, '0);
      cmp("rst_bv_a", {{(DEPTH*8-1){1'b0}}, bv_a}, '0);
      cmp("rst_id_a", {{(DEPTH*8-1){1'b0}}, id_a}, '0);
      cmp("rst_miso_a", {{(DEPTH*8-1){1'b0}}, if_a.MISO}, '0);
      cmp("rst_data_b", data_b, '0);
      RESET_N = 1'b1;

      // Reset landing mid-frame wipes completed writes and flags too.
      exp_flags = 3'b010;
      start(0); xfer(0, 8'h81, 0, 8'h00, 1); stop();
      start(0);
      xfer(0, 8'h01, 0, 8'h00, 0);
      xfer(0, 8'h07, 1, 8'h00, 0);
      exp_mem_a[8*7 +: 8] = 8'h99;
      xfer(0, 8'h99, 1, 8'h00, 1);
      bits(8'h55, 4);
      RESET_N = 1'b0;
      @(negedge SCLK);
      cmp("midrst_data_a", data_a, '0);
      cmp("midrst_flags_a", {{(DEPTH*8-3){1'b0}}, flags_a}, '0);
      cmp("midrst_bv_a", {{(DEPTH*8-1){1'b0}}, bv_a}, '0);
      cmp("midrst_miso_a", {{(DEPTH*8-1){1'b0}}, if_a.MISO}, '0);
      if_a.SS = 1'b1; if_a.MOSI = 1'b0;
      exp_mem_a = '0; exp_flags = 3'b000;
      @(negedge SCLK);
      RESET_N = 1'b1;
      @(negedge SCLK);

      start(0);
      xfer(0, 8'h01, 0, 8'h00, 0);
      xfer(0, 8'h05, 1, 8'h00, 0);
      exp_mem_a[47:40] = 8'hA5;
      xfer(0, 8'hA5, 1, 8'h00, 1);
      stop();

      // Burst write wrapping past the last byte.
      start(0);
      xfer(0, 8'h01, 0, 8'h00, 0);
      xfer(0, 8'h40, 1, 8'h00, 0);
      exp_mem_a[8*64 +: 8] = 8'h11; xfer(0, 8'h11, 1, 8'h00, 1);
      exp_mem_a[8*65 +: 8] = 8'h22; xfer(0, 8'h22, 1, 8'h00, 1);
      exp_mem_a[8*0  +: 8] = 8'h33; xfer(0, 8'h33, 1, 8'h00, 1);
      stop();

      // Preload and read back a burst, then a read wrapping 65 -> 0.
      start(0);
      xfer(0, 8'h01, 0, 8'h00, 0);
      xfer(0, 8'h03, 1, 8'h00, 0);
      exp_mem_a[8*3 +: 8] = 8'h5A; xfer(0, 8'h5A, 1, 8'h00, 1);
      exp_mem_a[8*4 +: 8] = 8'hC3; xfer(0, 8'hC3, 1, 8'h00, 1);
      stop();
      start(0);
      xfer(0, 8'h02, 0, 8'h00, 0);
      xfer(0, 8'h03, 1, 8'h00, 0);
      xfer(0, 8'h00, 1, 8'h5A, 1);
      xfer(0, 8'h00, 1, 8'hC3, 1);
      stop();
      start(0);
      xfer(0, 8'h02, 0, 8'h00, 0);
      xfer(0, 8'h41, 1, 8'h00, 0);
      xfer(0, 8'hFF, 1, 8'h22, 1);
      xfer(0, 8'hFF, 1, 8'h33, 1);
      stop();

      // Out-of-range write, then status read clears the error.
      start(0);
      xfer(0, 8'h01, 0, 8'h00, 0);
      exp_err = 1'b1;
      xfer(0, 8'h50, 1, 8'h00, 0);
      xfer(0, 8'hFF, 1, 8'h00, 1);
      stop();
      start(0);
      xfer(0, 8'h03, 0, 8'h00, 0);
      exp_err = 1'b0;
      xfer(0, 8'h00, 1, 8'h80, 0);
      stop();

      // Out-of-range read returns zeros; second status byte shows the cleared bit.
      start(0);
      xfer(0, 8'h02, 0, 8'h00, 0);
      exp_err = 1'b1;
      xfer(0, 8'h50, 1, 8'h00, 0);
      xfer(0, 8'h00, 1, 8'h00, 1);
      xfer(0, 8'h00, 1, 8'h00, 1);
      stop();
      start(0);
      xfer(0, 8'h03, 0, 8'h00, 0);
      exp_err = 1'b0;
      xfer(0, 8'h00, 1, 8'h80, 0);
      xfer(0, 8'h00, 1, 8'h00, 0);
      stop();

      // Flag opcodes, including a repeated set, an out-of-range index and a trailing byte.
      exp_flags = 3'b010; start(0); xfer(0, 8'h81, 0, 8'h00, 1); stop();
      exp_flags = 3'b110; start(0); xfer(0, 8'h82, 0, 8'h00, 1); stop();
      start(0); xfer(0, 8'h82, 0, 8'h00, 1); stop();
      exp_flags = 3'b100; start(0); xfer(0, 8'h41, 0, 8'h00, 1); stop();
      start(0);
      xfer(0, 8'h87, 0, 8'h00, 1);
      xfer(0, 8'h81, 1, 8'h00, 0);
      stop();
      start(0);
      xfer(0, 8'h03, 0, 8'h00, 0);
      xfer(0, 8'h00, 1, 8'h04, 0);
      stop();

      // Unknown opcode: the rest of the frame is ignored.
      start(0);
      xfer(0, 8'h55, 0, 8'h00, 0);
      xfer(0, 8'h01, 1, 8'h00, 0);
      xfer(0, 8'h07, 1, 8'h00, 0);
      stop();

      // Aborted data byte leaves mem[10] untouched; next frame decodes normally.
      start(0);
      xfer(0, 8'h01, 0, 8'h00, 0);
      xfer(0, 8'h0A, 1, 8'h00, 0);
      bits(8'hEE, 5);
      stop();
      start(0);
      xfer(0, 8'h01, 0, 8'h00, 0);
      xfer(0, 8'h0B, 1, 8'h00, 0);
      exp_mem_a[8*11 +: 8] = 8'h12;
      xfer(0, 8'h12, 1, 8'h00, 1);
      stop();

      // Two-byte address phase on the 16-bit instance.
      start(1);
      xfer(1, 8'h01, 0, 8'h00, 0);
      xfer(1, 8'h00, 1, 8'h00, 0);
      xfer(1, 8'h02, 1, 8'h00, 0);
      exp_mem_b[8*2 +: 8] = 8'h7E;
      xfer(1, 8'h7E, 1, 8'h00, 1);
      stop();

      repeat (4) @(negedge SCLK);
      cmp("queue_a_drained", q_a.size(), 0);
      cmp("queue_b_drained", q_b.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
